// File: rtl/game_datapath.sv
// Datapath for the memory game: latches setup, plays the ROM sequence on ledr,
// captures key presses, times the player, counts rounds and computes the score.
module game_datapath #(
    parameter int HALF_DIV   = 25_000_000,
    parameter int TIME_LIMIT = 9
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       r1,
    input  logic       r2,
    input  logic       e1,
    input  logic       e2,
    input  logic       e3,
    input  logic       e4,
    input  logic       sel,
    input  logic [7:0] setup_sw,
    input  logic [3:0] key_n,
    input  logic [3:0] seq_data,
    output logic [5:0] seq_addr,
    output logic [3:0] ledr,
    output logic       end_fpga,
    output logic       end_user,
    output logic       end_time,
    output logic       win,
    output logic       match,
    output logic [3:0] round,
    output logic [3:0] timer,
    output logic [1:0] level,
    output logic [7:0] score
);

    localparam int             HCW       = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
    localparam logic [HCW-1:0] HALF_LAST = HCW'(HALF_DIV - 1);
    localparam logic [3:0]     TIME_MAX  = 4'(TIME_LIMIT);

    logic [1:0]     level_reg;
    logic [1:0]     seq_sel_reg;
    logic [3:0]     max_round_reg;
    logic [3:0]     round_reg;
    logic [4:0]     fpga_idx;
    logic [4:0]     user_idx;
    logic [3:0]     timer_reg;
    logic [HCW-1:0] half_cnt;
    logic [2:0]     step_cnt;
    logic           sec_phase;
    logic           err;
    logic [3:0]     key_s1;
    logic [3:0]     key_s2;
    logic [3:0]     key_prev;

    logic           clear_run;
    logic           active;
    logic           half_tick;
    logic [4:0]     target;
    logic [2:0]     step_last;
    logic           step_end;
    logic           press;
    logic [3:0]     key_value;
    logic [3:0]     idx;
    logic [2:0]     level_mult;

    assign clear_run  = r1 | r2;
    assign active     = e2 | e3;
    assign half_tick  = active && (half_cnt == HALF_LAST);
    assign target     = {1'b0, round_reg} + 5'd1;
    // Step period is 8>>level half-ticks, so the last count is 7>>level.
    assign step_last  = 3'd7 >> level_reg;
    assign step_end   = (step_cnt == step_last);
    assign key_value  = ~key_s2;
    assign press      = e2 && !end_user && (key_prev == 4'hF) && (key_s2 != 4'hF);

    // Setup registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            level_reg     <= 2'd0;
            seq_sel_reg   <= 2'd0;
            max_round_reg <= 4'd0;
        end else if (r1) begin
            level_reg     <= 2'd0;
            seq_sel_reg   <= 2'd0;
            max_round_reg <= 4'd0;
        end else if (e1 && !r2) begin
            level_reg     <= setup_sw[7:6];
            seq_sel_reg   <= setup_sw[5:4];
            max_round_reg <= setup_sw[3:0];
        end
    end

    // Round counter, saturating at 15
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            round_reg <= 4'd0;
        end else if (r1) begin
            round_reg <= 4'd0;
        end else if (e4 && !r2 && match && (round_reg != 4'hF)) begin
            round_reg <= round_reg + 4'd1;
        end
    end

    // Half-tick prescaler, idle-cleared so each play phase starts on a full tick
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            half_cnt <= '0;
        end else if (clear_run || !active) begin
            half_cnt <= '0;
        end else if (half_cnt == HALF_LAST) begin
            half_cnt <= '0;
        end else begin
            half_cnt <= half_cnt + 1'b1;
        end
    end

    // FPGA playback stepping
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            step_cnt <= 3'd0;
            fpga_idx <= 5'd0;
        end else if (clear_run) begin
            step_cnt <= 3'd0;
            fpga_idx <= 5'd0;
        end else if (e3 && half_tick && !end_fpga) begin
            if (step_end) begin
                step_cnt <= 3'd0;
                fpga_idx <= fpga_idx + 5'd1;
            end else begin
                step_cnt <= step_cnt + 3'd1;
            end
        end
    end

    // Seconds timer: two half-ticks per second, saturating at the limit
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sec_phase <= 1'b0;
            timer_reg <= 4'd0;
        end else if (clear_run) begin
            sec_phase <= 1'b0;
            timer_reg <= 4'd0;
        end else if (e2 && half_tick) begin
            sec_phase <= ~sec_phase;
            if (sec_phase && (timer_reg != TIME_MAX)) begin
                timer_reg <= timer_reg + 4'd1;
            end
        end
    end

    // Key synchroniser; free-running so a key held across phases never looks like a new press
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            key_s1   <= 4'd0;
            key_s2   <= 4'd0;
            key_prev <= 4'd0;
        end else begin
            key_s1   <= key_n;
            key_s2   <= key_s1;
            key_prev <= key_s2;
        end
    end

    // Player input capture and sticky error
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            user_idx <= 5'd0;
            err      <= 1'b0;
        end else if (clear_run) begin
            user_idx <= 5'd0;
            err      <= 1'b0;
        end else if (press) begin
            user_idx <= user_idx + 5'd1;
            if (key_value != seq_data) begin
                err <= 1'b1;
            end
        end
    end

    assign idx        = e3 ? fpga_idx[3:0] : user_idx[3:0];
    assign seq_addr   = {seq_sel_reg, idx};
    assign end_fpga   = (fpga_idx == target);
    assign end_user   = (user_idx == target);
    assign ledr       = (e3 && !end_fpga) ? seq_data : 4'd0;
    assign end_time   = e2 && (timer_reg == TIME_MAX);
    assign match      = !err && end_user;
    assign win        = (round_reg >= max_round_reg);
    assign round      = round_reg;
    assign timer      = timer_reg;
    assign level      = level_reg;
    assign level_mult = {1'b0, level_reg} + 3'd1;
    assign score      = sel ? ({2'b00, round_reg, 2'b00} * {5'b00000, level_mult}) : 8'd0;

endmodule

// File: tb/tb_game_datapath.sv
// Directed bench for game_datapath with a small ROM model and a short half-tick.
module tb_game_datapath;

    localparam int HALF_DIV = 4;

    logic       clock;
    logic       reset;
    logic       r1, r2, e1, e2, e3, e4, sel;
    logic [7:0] setup_sw;
    logic [3:0] key_n;
    logic [3:0] seq_data;
    logic [5:0] seq_addr;
    logic [3:0] ledr;
    logic       end_fpga, end_user, end_time, win, match;
    logic [3:0] round;
    logic [3:0] timer;
    logic [1:0] level;
    logic [7:0] score;

    logic [3:0] rom [64];
    int total;
    int bad;

    game_datapath #(.HALF_DIV(HALF_DIV), .TIME_LIMIT(9)) dut (
        .clock(clock), .reset(reset), .r1(r1), .r2(r2),
        .e1(e1), .e2(e2), .e3(e3), .e4(e4), .sel(sel),
        .setup_sw(setup_sw), .key_n(key_n), .seq_data(seq_data),
        .seq_addr(seq_addr), .ledr(ledr),
        .end_fpga(end_fpga), .end_user(end_user), .end_time(end_time),
        .win(win), .match(match), .round(round), .timer(timer),
        .level(level), .score(score)
    );

    assign seq_data = rom[seq_addr];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic pulse_r2();
        r2 = 1'b1;
        tick(1);
        r2 = 1'b0;
    endtask

    task automatic press(input logic [3:0] v);
        key_n = ~v;
        tick(4);
        key_n = 4'hF;
        tick(4);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        tick(1);
        total++; if (round !== 4'd0) begin bad++; $display("FAIL reset_round got=%0h want=0", round); end
        total++; if (timer !== 4'd0) begin bad++; $display("FAIL reset_timer got=%0h want=0", timer); end
        total++; if (level !== 2'd0) begin bad++; $display("FAIL reset_level got=%0h want=0", level); end
        total++; if ({end_fpga, end_user, end_time, match} !== 4'b0000) begin
            bad++; $display("FAIL reset_status got=%b want=0000", {end_fpga, end_user, end_time, match});
        end
        total++; if (ledr !== 4'd0) begin bad++; $display("FAIL reset_ledr got=%0h want=0", ledr); end
        total++; if (score !== 8'd0) begin bad++; $display("FAIL reset_score got=%0h want=0", score); end
    endtask

    task automatic test_setup();
        setup_sw = 8'hC2;
        e1 = 1'b1;
        tick(1);
        e1 = 1'b0;
        setup_sw = 8'h00;
        tick(1);
        total++; if (level !== 2'd3) begin bad++; $display("FAIL setup_level got=%0h want=3", level); end
        total++; if (win !== 1'b0) begin bad++; $display("FAIL setup_win got=%b want=0", win); end
        total++; if ({end_fpga, end_user, end_time, match} !== 4'b0000) begin
            bad++; $display("FAIL setup_status got=%b want=0000", {end_fpga, end_user, end_time, match});
        end
    endtask

    task automatic test_fpga_play();
        pulse_r2();
        e3 = 1'b1;
        #1;
        total++; if (ledr !== 4'h1) begin bad++; $display("FAIL play_ledr_start got=%0h want=1", ledr); end
        total++; if (seq_addr !== 6'd0) begin bad++; $display("FAIL play_addr_start got=%0h want=0", seq_addr); end
        tick(3);
        total++; if ({end_fpga, ledr} !== 5'b0_0001) begin
            bad++; $display("FAIL play_before_tick got=%b want=00001", {end_fpga, ledr});
        end
        tick(1);
        total++; if (end_fpga !== 1'b1) begin bad++; $display("FAIL play_end_fpga got=%b want=1", end_fpga); end
        total++; if (ledr !== 4'd0) begin bad++; $display("FAIL play_ledr_end got=%0h want=0", ledr); end
        tick(8);
        total++; if ({end_fpga, seq_addr} !== {1'b1, 6'd1}) begin
            bad++; $display("FAIL play_frozen got=%b/%0h want=1/1", end_fpga, seq_addr);
        end
        e3 = 1'b0;
        tick(1);
    endtask

    task automatic test_user_match();
        pulse_r2();
        e2 = 1'b1;
        tick(2);
        press(4'h1);
        total++; if (end_user !== 1'b1) begin bad++; $display("FAIL match_end_user got=%b want=1", end_user); end
        total++; if (match !== 1'b1) begin bad++; $display("FAIL match_match got=%b want=1", match); end
        e2 = 1'b0;
        e4 = 1'b1;
        tick(1);
        e4 = 1'b0;
        total++; if (round !== 4'd1) begin bad++; $display("FAIL match_round got=%0h want=1", round); end
        total++; if (win !== 1'b0) begin bad++; $display("FAIL match_win got=%b want=0", win); end
    endtask

    task automatic test_user_mismatch();
        pulse_r2();
        e2 = 1'b1;
        tick(2);
        press(4'h1);
        total++; if ({end_user, match} !== 2'b00) begin
            bad++; $display("FAIL mism_mid got=%b want=00", {end_user, match});
        end
        press(4'h4);
        total++; if (end_user !== 1'b1) begin bad++; $display("FAIL mism_end_user got=%b want=1", end_user); end
        total++; if (match !== 1'b0) begin bad++; $display("FAIL mism_match got=%b want=0", match); end
        press(4'h1);
        total++; if ({end_user, seq_addr} !== {1'b1, 6'd2}) begin
            bad++; $display("FAIL mism_ignored got=%b/%0h want=1/2", end_user, seq_addr);
        end
        e2 = 1'b0;
        e4 = 1'b1;
        tick(1);
        e4 = 1'b0;
        total++; if (round !== 4'd1) begin bad++; $display("FAIL mism_round got=%0h want=1", round); end
    endtask

    task automatic test_timer();
        pulse_r2();
        total++; if ({timer, end_time} !== 5'd0) begin
            bad++; $display("FAIL timer_clear got=%0h/%b want=0/0", timer, end_time);
        end
        e2 = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            tick(7);
            total++; if (timer !== 4'(k - 1)) begin
                bad++; $display("FAIL timer_pre k=%0d got=%0d want=%0d", k, timer, k - 1);
            end
            tick(1);
            total++; if ({timer, end_time} !== {4'(k), (k == 9)}) begin
                bad++; $display("FAIL timer_step k=%0d got=%0d/%b want=%0d/%b", k, timer, end_time, k, (k == 9));
            end
        end
        tick(16);
        total++; if ({timer, end_time} !== {4'd9, 1'b1}) begin
            bad++; $display("FAIL timer_sat got=%0d/%b want=9/1", timer, end_time);
        end
        e2 = 1'b0;
        #1;
        total++; if (end_time !== 1'b0) begin bad++; $display("FAIL timer_gate got=%b want=0", end_time); end
        tick(1);
    endtask

    task automatic test_score_win();
        pulse_r2();
        e2 = 1'b1;
        tick(2);
        press(4'h1);
        press(4'h2);
        total++; if (match !== 1'b1) begin bad++; $display("FAIL win_match1 got=%b want=1", match); end
        e4 = 1'b1;
        r2 = 1'b1;
        tick(1);
        e4 = 1'b0;
        r2 = 1'b0;
        total++; if ({round, match} !== {4'd1, 1'b0}) begin
            bad++; $display("FAIL win_r2_priority got=%0h/%b want=1/0", round, match);
        end
        press(4'h1);
        press(4'h2);
        total++; if (match !== 1'b1) begin bad++; $display("FAIL win_match2 got=%b want=1", match); end
        e2 = 1'b0;
        e4 = 1'b1;
        tick(1);
        e4 = 1'b0;
        total++; if ({round, win} !== {4'd2, 1'b1}) begin
            bad++; $display("FAIL win_round got=%0h/%b want=2/1", round, win);
        end
        setup_sw = 8'h42;
        e1 = 1'b1;
        tick(1);
        e1 = 1'b0;
        total++; if ({level, win} !== {2'd1, 1'b1}) begin
            bad++; $display("FAIL win_level got=%0h/%b want=1/1", level, win);
        end
        total++; if (score !== 8'd0) begin bad++; $display("FAIL win_score_nosel got=%0d want=0", score); end
        sel = 1'b1;
        #1;
        total++; if (score !== 8'd16) begin bad++; $display("FAIL win_score got=%0d want=16", score); end
        r1 = 1'b1;
        tick(1);
        r1 = 1'b0;
        total++; if ({round, level, score} !== 14'd0) begin
            bad++; $display("FAIL win_r1 got=%0h/%0h/%0d want=0/0/0", round, level, score);
        end
        sel = 1'b0;
    endtask

    task automatic test_async_reset();
        setup_sw = 8'hC2;
        e1 = 1'b1;
        tick(1);
        e1 = 1'b0;
        e2 = 1'b1;
        tick(20);
        total++; if (timer !== 4'd2) begin bad++; $display("FAIL async_pre_timer got=%0d want=2", timer); end
        #3;
        reset = 1'b1;
        #1;
        total++; if ({timer, level} !== 6'd0) begin
            bad++; $display("FAIL async_immediate got=%0d/%0h want=0/0", timer, level);
        end
        tick(3);
        total++; if (timer !== 4'd0) begin bad++; $display("FAIL async_hold got=%0d want=0", timer); end
        reset = 1'b0;
        e2 = 1'b0;
        tick(1);
    endtask

    initial begin
        total = 0;
        bad = 0;
        for (int i = 0; i < 64; i++) rom[i] = 4'h8;
        rom[0] = 4'h1;
        rom[1] = 4'h2;
        reset = 1'b1;
        r1 = 1'b0; r2 = 1'b0;
        e1 = 1'b0; e2 = 1'b0; e3 = 1'b0; e4 = 1'b0;
        sel = 1'b0;
        setup_sw = 8'h00;
        key_n = 4'hF;

        test_reset();
        test_setup();
        test_fpga_play();
        test_user_match();
        test_user_mismatch();
        test_timer();
        test_score_win();
        test_async_reset();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
